uart_duplex_param: RTL and testbench



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_duplex_param.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_uart_duplex_param.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised duplex UART.
package uart_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_PARITY,
        T_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    // Parity bit to transmit (or expect) for a data word zero-extended to 9 bits.
    // Even: data plus parity carries an even number of ones; odd: an odd number.
    function automatic logic calc_parity(input logic [8:0] data, input parity_mode_t mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received frames {data, parity_err, frame_err}.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || pop);
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; data needs no reset since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_duplex_param.sv
// Parametrised full-duplex UART with valid/ready TX, mid-bit RX sampling,
// glitch-rejecting start detection, error flags and an RX FIFO.
// Optional macro UART_LOOPBACK_EN adds a loopback port routing TX into RX.
module uart_duplex_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 1,
    parameter int STOP_BITS     = 1,
    parameter int CLK_DIV       = 5208,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_pop,
    output logic                 rx_overrun,
    input  logic                 overrun_clr,
    output logic                 busy
`ifdef UART_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit            PAR_EN    = (PARITY_MODE != 0);
    localparam parity_mode_t  PAR_MODE  = parity_mode_t'(PARITY_MODE);
    localparam int            EW        = DATA_BITS + 2;

    // ---------------- RX synchroniser ----------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_bit;

    // Two-flop synchroniser for the asynchronous rx pin; idles high.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ---------------- TX datapath/FSM ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_bit_q, tx_bit_d;

`ifdef UART_LOOPBACK_EN
    assign rx_bit = loopback ? tx_bit_q : rx_sync_q;
    assign tx     = loopback ? 1'b1 : tx_bit_q;
`else
    assign rx_bit = rx_sync_q;
    assign tx     = tx_bit_q;
`endif

    assign tx_ready = (tx_state_q == T_IDLE);

    // TX state register; the line bit is registered so the pin never glitches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_bit_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    // TX next state: each bit lasts CLK_DIV cycles; the next line bit is chosen on the transition.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_bit_d   = tx_bit_q;
        case (tx_state_q)
            T_IDLE: begin
                tx_bit_d = 1'b1;
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_par_d   = calc_parity(9'(tx_data), PAR_MODE);
                    tx_cnt_d   = '0;
                    tx_bit_d   = 1'b0;
                    tx_state_d = T_START;
                end
            end
            T_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_bit_d   = tx_shift_q[0];
                    tx_state_d = T_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == LAST_DATA) begin
                        tx_idx_d = '0;
                        if (PAR_EN) begin
                            tx_bit_d   = tx_par_q;
                            tx_state_d = T_PARITY;
                        end else begin
                            tx_bit_d   = 1'b1;
                            tx_state_d = T_STOP;
                        end
                    end else begin
                        tx_idx_d   = tx_idx_q + 4'd1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        tx_bit_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_PARITY: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_bit_d   = 1'b1;
                    tx_state_d = T_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_STOP: begin
                tx_bit_d = 1'b1;
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == LAST_STOP) begin
                        tx_state_d = T_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_bit_d   = 1'b1;
                tx_state_d = T_IDLE;
            end
        endcase
    end

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push;
    logic [EW-1:0]        rx_push_entry;

    // RX state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // RX next state: confirm start at half a bit, then sample every CLK_DIV (mid-bit).
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_idx_d      = rx_idx_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_d     = rx_perr_q;
        rx_push       = 1'b0;
        rx_push_entry = {rx_shift_q, rx_perr_q, ~rx_bit};
        case (rx_state_q)
            R_IDLE: begin
                if (!rx_bit) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_START;
                end
            end
            R_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    if (rx_bit) begin
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_idx_d   = '0;
                        rx_perr_d  = 1'b0;
                        rx_state_d = R_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == LAST_DATA) begin
                        rx_state_d = PAR_EN ? R_PARITY : R_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_PARITY: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = (rx_bit != calc_parity(9'(rx_shift_q), PAR_MODE));
                    rx_state_d = R_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = 1'b1;
                    rx_state_d = R_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // ---------------- RX FIFO and overrun ----------------
    logic [EW-1:0] fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          rx_overrun_q;
    logic          overrun_set;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (rx_push),
        .push_data (rx_push_entry),
        .pop       (rx_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_data       = fifo_head[EW-1:2];
    assign rx_parity_err = fifo_head[1];
    assign rx_frame_err  = fifo_head[0];
    assign rx_valid      = !fifo_empty;
    assign overrun_set   = rx_push && fifo_full && !rx_pop;
    assign rx_overrun    = rx_overrun_q;

    // Sticky overrun flag; a new overrun wins over a simultaneous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_overrun_q <= 1'b0;
        end else if (overrun_set) begin
            rx_overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            rx_overrun_q <= 1'b0;
        end
    end

    assign busy = (rx_state_q != R_IDLE) || (tx_state_q != T_IDLE);

endmodule

// File: tb/tb_uart_duplex_param.sv
// Self-checking bench for uart_duplex_param (CLK_DIV=16, 8 data bits, even parity, 1 stop).
// With UART_LOOPBACK_EN defined the loopback port is connected and exercised too.
module tb_uart_duplex_param;
    localparam int DB    = 8;
    localparam int PM    = 1;
    localparam int SB    = 1;
    localparam int CD    = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = (1 + DB + ((PM != 0) ? 1 : 0) + SB) * CD;
    localparam int GAP   = 24;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          rx = 1'b1;
    logic          tx;
    logic [DB-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_parity_err;
    logic          rx_frame_err;
    logic          rx_valid;
    logic          rx_pop = 1'b0;
    logic          rx_overrun;
    logic          overrun_clr = 1'b0;
    logic          busy;
`ifdef UART_LOOPBACK_EN
    logic          loopback = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_duplex_param #(
        .DATA_BITS     (DB),
        .PARITY_MODE   (PM),
        .STOP_BITS     (SB),
        .CLK_DIV       (CD),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rx            (rx),
        .tx            (tx),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop),
        .rx_overrun    (rx_overrun),
        .overrun_clr   (overrun_clr),
        .busy          (busy)
`ifdef UART_LOOPBACK_EN
        ,
        .loopback      (loopback)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } entry_t;

    logic   exp_tx_q[$];      // expected tx pin, one element per clock of an in-flight frame
    entry_t rx_model_q[$];    // expected FIFO contents, head first
    logic   model_overrun = 1'b0;
    logic   tx_check_en = 1'b0;
    logic   rx_check_en = 1'b0;

    function automatic logic exp_parity(input logic [DB-1:0] d);
        int ones;
        ones = $countones(d);
        return (PM == 2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic queue_tx_frame(input logic [DB-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (PM != 0) bits.push_back(exp_parity(d));
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < CD; c++) exp_tx_q.push_back(bits[i]);
        end
    endtask

    task automatic model_push(input entry_t e);
        if (rx_model_q.size() >= DEPTH) model_overrun = 1'b1;
        else rx_model_q.push_back(e);
    endtask

    // Single compare process: checks the DUT against the model every cycle it is meaningful.
    always @(negedge clk) begin
        if (tx_check_en) begin
            if (exp_tx_q.size() > 0) begin
                check("tx_bit", tx, exp_tx_q.pop_front());
                check("tx_ready_in_frame", tx_ready, 1'b0);
            end else begin
                check("tx_idle", tx, 1'b1);
                check("tx_ready_idle", tx_ready, 1'b1);
            end
        end
        if (rx_check_en) begin
            check("rx_valid", rx_valid, rx_model_q.size() > 0);
            if (rx_model_q.size() > 0) begin
                check("rx_data", rx_data, rx_model_q[0].data);
                check("rx_parity_err", rx_parity_err, rx_model_q[0].perr);
                check("rx_frame_err", rx_frame_err, rx_model_q[0].ferr);
            end
            check("rx_overrun", rx_overrun, model_overrun);
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_tx(input logic [DB-1:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_ready) begin
            check("tx_accept_timeout", 1'b0, 1'b1);
            tx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = DB'($urandom);
        queue_tx_frame(d);
    endtask

    task automatic drive_rx(input logic [DB-1:0] d, input logic bad_par, input logic bad_stop,
                            input logic clr_at_stop, output int lat);
        logic   bits[$];
        entry_t e;
        lat = -1;
        rx_check_en = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (PM != 0) bits.push_back(exp_parity(d) ^ bad_par);
        @(negedge clk);
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (CD) @(negedge clk);
        end
        rx = ~bad_stop;
        if (clr_at_stop) overrun_clr = 1'b1;
        for (int c = 1; c <= CD; c++) begin
            @(negedge clk);
            if (lat < 0 && rx_valid) lat = c;
            if (overrun_clr && !busy) overrun_clr = 1'b0;
        end
        overrun_clr = 1'b0;
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
        e.data = d;
        e.perr = bad_par && (PM != 0);
        e.ferr = bad_stop;
        model_push(e);
        rx_check_en = 1'b1;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        rx_pop = 1'b1;
        @(posedge clk);
        #1;
        rx_pop = 1'b0;
        if (rx_model_q.size() > 0) void'(rx_model_q.pop_front());
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #600000;
        $display("FAIL watchdog: got no completion, expected completion within budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int   lat;
        logic lit_a5 [11];
        lit_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tx_check_en = 1'b1;
        rx_check_en = 1'b1;

        // TX 0xA5 against hand-computed line levels and ready-low duration
        send_tx(8'hA5);
        fork
            begin
                for (int i = 0; i < 11; i++) begin
                    repeat (8) @(negedge clk);
                    check($sformatf("a5_bit%0d", i), tx, lit_a5[i]);
                    repeat (8) @(negedge clk);
                end
            end
            begin
                int low_cnt;
                low_cnt = 0;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (tx_ready) break;
                    low_cnt++;
                end
                check("a5_ready_low_cycles", low_cnt, FRAME);
            end
        join
        repeat (4) @(negedge clk);

        // RX 0x3C good frame, latency, pop, pop-while-empty
        drive_rx(8'h3C, 1'b0, 1'b0, 1'b0, lat);
        check("rx3c_latency_window", (lat >= 9 && lat <= 13), 1'b1);
        check("rx3c_data_lit", rx_data, 8'h3C);
        check("rx3c_flags_lit", {rx_parity_err, rx_frame_err}, 2'b00);
        pop_rx();
        @(negedge clk);
        check("rx3c_valid_after_pop", rx_valid, 1'b0);
        pop_rx();
        repeat (2) @(negedge clk);

        // Error flags: bad parity, then bad stop
        drive_rx(8'h3C, 1'b1, 1'b0, 1'b0, lat);
        drive_rx(8'h81, 1'b0, 1'b1, 1'b0, lat);
        check("perr_entry_lit", {rx_data, rx_parity_err, rx_frame_err}, {8'h3C, 2'b10});
        pop_rx();
        @(negedge clk);
        check("ferr_entry_lit", {rx_data, rx_parity_err, rx_frame_err}, {8'h81, 2'b01});
        pop_rx();
        repeat (2) @(negedge clk);

        // Start glitch of 5 cycles
        rx_check_en = 1'b0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rx_check_en = 1'b1;
        check("glitch_no_entry", rx_valid, 1'b0);
        check("glitch_busy", busy, 1'b0);

        // Random concurrent traffic
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    repeat ($urandom_range(0, 50)) @(negedge clk);
                    send_tx(DB'($urandom));
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    drive_rx(DB'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                             1'b0, lat);
                    if (rx_model_q.size() > 0 && $urandom_range(0, 1) == 1) pop_rx();
                end
            end
        join
        repeat (FRAME + 4) @(negedge clk);

        // Drain, clear any random overrun, then overflow the FIFO
        while (rx_model_q.size() > 0) pop_rx();
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        model_overrun = 1'b0;
        for (int n = 0; n < 5; n++) drive_rx(DB'($urandom), 1'b0, 1'b0, 1'b0, lat);
        check("ovr_set_lit", rx_overrun, 1'b1);
        check("ovr_occupancy", rx_model_q.size(), DEPTH);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        model_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared_lit", rx_overrun, 1'b0);
        drive_rx(DB'($urandom), 1'b0, 1'b0, 1'b1, lat);
        check("ovr_set_wins_lit", rx_overrun, 1'b1);

        // Asynchronous reset in the middle of TX and RX frames
        tx_check_en = 1'b0;
        rx_check_en = 1'b0;
        send_tx(8'hC3);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_rx_overrun", rx_overrun, 1'b0);
        exp_tx_q.delete();
        rx_model_q.delete();
        model_overrun = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        tx_check_en = 1'b1;
        rx_check_en = 1'b1;
        send_tx(8'h0F);
        repeat (FRAME + 4) @(negedge clk);

`ifdef UART_LOOPBACK_EN
        // Loopback: RX receives the internal TX bit while the pin stays high
        tx_check_en = 1'b0;
        rx_check_en = 1'b0;
        @(negedge clk);
        loopback = 1'b1;
        send_tx(8'h5A);
        for (int c = 0; c < FRAME + 20; c++) begin
            @(negedge clk);
            check("loopback_tx_pin", tx, 1'b1);
        end
        check("loopback_rx_valid", rx_valid, 1'b1);
        check("loopback_rx_data_lit", rx_data, 8'h5A);
        check("loopback_flags", {rx_parity_err, rx_frame_err}, 2'b00);
        model_push('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
        loopback = 1'b0;
        exp_tx_q.delete();
        @(negedge clk);
        tx_check_en = 1'b1;
        rx_check_en = 1'b1;
        pop_rx();
        repeat (4) @(negedge clk);
`endif

        tx_check_en = 1'b0;
        rx_check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
